// File: rtl/ppu_cpu_bridge_if.sv
// ppu_cpu_bridge_if: CPU register bus and VRAM request/grant port of the PPU CPU bridge
interface ppu_cpu_bridge_if #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 8
);
   logic              cpu_cs;
   logic              cpu_rw;
   logic [2:0]        cpu_addr;
   logic [DATA_W-1:0] cpu_data_i;
   logic [DATA_W-1:0] cpu_data_o;
   logic              vram_req;
   logic              vram_we;
   logic [ADDR_W-1:0] vram_addr;
   logic [DATA_W-1:0] vram_wdata;
   logic              vram_gnt;
   logic              vram_rvalid;
   logic [DATA_W-1:0] vram_rdata;
   modport master (
      output cpu_cs, cpu_rw, cpu_addr, cpu_data_i, vram_gnt, vram_rvalid, vram_rdata,
      input  cpu_data_o, vram_req, vram_we, vram_addr, vram_wdata
   );
   modport slave (
      input  cpu_cs, cpu_rw, cpu_addr, cpu_data_i, vram_gnt, vram_rvalid, vram_rdata,
      output cpu_data_o, vram_req, vram_we, vram_addr, vram_wdata
   );
endinterface

// File: rtl/ppu_cpu_bridge.sv
// ppu_cpu_bridge: PPU $2000-$2007 register front end with posted PPUDATA writes
// and a request/grant VRAM port shared with render fetches.
module ppu_cpu_bridge #(
   parameter int ADDR_W     = 14,
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int OAM_AW     = 8
) (
   input  logic              clk,
   input  logic              rst,
   ppu_cpu_bridge_if.slave   bus,
   output logic              nmi,
   input  logic              vblank_set,
   input  logic              vblank_clr,
   input  logic              sp0,
   input  logic              sp_of,
   output logic [7:0]        ctrl,
   output logic [7:0]        mask,
   output logic [ADDR_W:0]   t,
   output logic [2:0]        fine_x,
   output logic [ADDR_W:0]   v,
   output logic              v_load,
   input  logic [DATA_W-1:0] pal_rdata,
   output logic [OAM_AW-1:0] oam_addr,
   output logic              oam_we,
   output logic [DATA_W-1:0] oam_wdata,
   input  logic [DATA_W-1:0] oam_rdata,
   output logic              fifo_ovf
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [1:0] IDLE = 2'd0, WR = 2'd1, RD = 2'd2, RWAIT = 2'd3;
   logic cs_r, w, vblank_flag, pend, stale;
   logic [1:0] state, state_n;
   logic [DATA_W-1:0] d, readbuf;
   logic [ADDR_W-1:0] raddr;
   logic [ADDR_W+DATA_W-1:0] fifo [FIFO_DEPTH];
   logic [PW-1:0] wp, rp;
   logic [PW:0] cnt, cnt_n;
   logic rd_s, wr_s, wr0, wr1, wr3, wr4, wr5, wr6, wr7, rd2, rd4, rd7;
   logic push, pop, full, pal, hit;
   logic [ADDR_W:0] v_inc;
   assign d      = bus.cpu_data_i;
   assign rd_s   = bus.cpu_cs & ~cs_r & bus.cpu_rw;
   assign wr_s   = bus.cpu_cs & ~cs_r & ~bus.cpu_rw;
   assign wr0    = wr_s & bus.cpu_addr == 3'd0;
   assign wr1    = wr_s & bus.cpu_addr == 3'd1;
   assign wr3    = wr_s & bus.cpu_addr == 3'd3;
   assign wr4    = wr_s & bus.cpu_addr == 3'd4;
   assign wr5    = wr_s & bus.cpu_addr == 3'd5;
   assign wr6    = wr_s & bus.cpu_addr == 3'd6;
   assign wr7    = wr_s & bus.cpu_addr == 3'd7;
   assign rd2    = rd_s & bus.cpu_addr == 3'd2;
   assign rd4    = rd_s & bus.cpu_addr == 3'd4;
   assign rd7    = rd_s & bus.cpu_addr == 3'd7;
   assign full   = cnt == (PW+1)'(FIFO_DEPTH);
   assign pop    = state == WR & bus.vram_gnt;
   assign push   = wr7 & (~full | pop);
   assign cnt_n  = cnt + (PW+1)'(push) - (PW+1)'(pop);
   assign pal    = v[13:8] == 6'h3F;
   // returning read data is only kept if no newer PPUDATA read re-targeted the refill
   assign hit    = state == RWAIT & bus.vram_rvalid & ~stale & ~rd7;
   assign v_inc  = ctrl[2] ? (ADDR_W+1)'(32) : (ADDR_W+1)'(1);
   assign nmi    = vblank_flag & ctrl[7];
   assign bus.vram_req   = state == WR | state == RD;
   assign bus.vram_we    = state == WR;
   assign bus.vram_addr  = state == WR ? fifo[rp][ADDR_W+DATA_W-1:DATA_W] : raddr;
   assign bus.vram_wdata = fifo[rp][DATA_W-1:0];
   always_comb
      case (state)
         IDLE:    state_n = cnt != '0 ? WR : pend ? RD : IDLE;
         WR:      state_n = ~bus.vram_gnt | cnt_n != '0 ? WR : (pend | rd7) ? RD : IDLE;
         RD:      state_n = bus.vram_gnt ? RWAIT : RD;
         default: state_n = bus.vram_rvalid ? IDLE : RWAIT;
      endcase
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cs_r <= 1'b0;
         w <= 1'b0;
         vblank_flag <= 1'b0;
         pend <= 1'b0;
         stale <= 1'b0;
         state <= IDLE;
         readbuf <= '0;
         raddr <= '0;
         wp <= '0;
         rp <= '0;
         cnt <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) fifo[i] <= '0;
         bus.cpu_data_o <= '0;
         ctrl <= '0;
         mask <= '0;
         t <= '0;
         fine_x <= '0;
         v <= '0;
         v_load <= 1'b0;
         oam_addr <= '0;
         oam_we <= 1'b0;
         oam_wdata <= '0;
         fifo_ovf <= 1'b0;
      end else begin
         cs_r <= bus.cpu_cs;
         state <= state_n;
         v_load <= wr6 & w;
         oam_we <= wr4;
         if (wr4) oam_wdata <= d;
         if (wr_s) bus.cpu_data_o <= d;
         else if (rd2) bus.cpu_data_o <= {vblank_flag, sp0, sp_of, bus.cpu_data_o[4:0]};
         else if (rd4) bus.cpu_data_o <= oam_rdata;
         else if (rd7) bus.cpu_data_o <= pal ? pal_rdata : readbuf;
         if (wr0) begin
            ctrl <= d[7:0];
            t[11:10] <= d[1:0];
         end
         if (wr1) mask <= d[7:0];
         if (wr3) oam_addr <= d[OAM_AW-1:0];
         else if (oam_we) oam_addr <= oam_addr + OAM_AW'(1);
         if (wr5 & ~w) begin
            t[4:0] <= d[7:3];
            fine_x <= d[2:0];
         end
         if (wr5 & w) begin
            t[9:5] <= d[7:3];
            t[14:12] <= d[2:0];
         end
         if (wr6 & ~w) t[14:8] <= {1'b0, d[5:0]};
         if (wr6 & w) begin
            t[7:0] <= d[7:0];
            v <= {t[ADDR_W:8], d[7:0]};
         end else if (wr7 | rd7) v <= v + v_inc;
         if (rd2) w <= 1'b0;
         else if (wr5 | wr6) w <= ~w;
         if (rd2 | vblank_clr) vblank_flag <= 1'b0;
         else if (vblank_set) vblank_flag <= 1'b1;
         if (rd2) fifo_ovf <= 1'b0;
         else if (wr7 & ~push) fifo_ovf <= 1'b1;
         if (push) begin
            fifo[wp] <= {v[ADDR_W-1:0], d};
            wp <= wp + PW'(1);
         end
         if (pop) rp <= rp + PW'(1);
         cnt <= cnt_n;
         // palette reads refill from the nametable mirror underneath
         if (rd7) begin
            pend <= 1'b1;
            raddr <= pal ? v[ADDR_W-1:0] & ~(ADDR_W'(4096)) : v[ADDR_W-1:0];
         end else if (hit) pend <= 1'b0;
         if (hit) readbuf <= bus.vram_rdata;
         stale <= state == RWAIT & bus.vram_rvalid ? 1'b0
                : stale | (rd7 & (state == RWAIT | (state == RD & bus.vram_gnt)));
      end
endmodule

// File: tb/tb_ppu_cpu_bridge.sv
// tb_ppu_cpu_bridge: register table, VRAM write scoreboard and multi-cycle corner sequences
module tb_ppu_cpu_bridge;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   ppu_cpu_bridge_if #(.ADDR_W(14), .DATA_W(8)) bus();
   logic nmi, vblank_set, vblank_clr, sp0, sp_of, v_load, oam_we, fifo_ovf;
   logic [7:0] ctrl, mask, pal_rdata, oam_wdata, oam_rdata, oam_addr;
   logic [14:0] t, v;
   logic [2:0] fine_x;
   ppu_cpu_bridge #(.ADDR_W(14), .DATA_W(8), .FIFO_DEPTH(4), .OAM_AW(8)) dut (
      .clk(clk), .rst(rst), .bus(bus), .nmi(nmi),
      .vblank_set(vblank_set), .vblank_clr(vblank_clr), .sp0(sp0), .sp_of(sp_of),
      .ctrl(ctrl), .mask(mask), .t(t), .fine_x(fine_x), .v(v), .v_load(v_load),
      .pal_rdata(pal_rdata), .oam_addr(oam_addr), .oam_we(oam_we),
      .oam_wdata(oam_wdata), .oam_rdata(oam_rdata), .fifo_ovf(fifo_ovf)
   );
   typedef struct {
      logic rw; logic [2:0] a; logic [7:0] d;
      logic [7:0] ctrl, mask; logic [14:0] t; logic [2:0] fx; logic [14:0] v; logic [7:0] dout;
   } vec_t;
   vec_t tbl[14];
   int n_vec = 0, n_err = 0;
   logic [7:0] mem [16384];
   logic [21:0] exp_q[$];
   bit tlog[$];
   int rd_cnt = 0, rd_lat = 2, vl_n = 0, oam_n = 0;
   logic [13:0] rd_a, last_ra;
   logic [7:0] oam_la, oam_ld;
   task automatic chk(input string nm, input logic [95:0] got, input logic [95:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", nm, got, exp);
      end
   endtask
   // VRAM model with fixed read latency, write scoreboard and strobe monitors
   always @(negedge clk) begin
      bus.vram_rvalid = 1'b0;
      if (rst) rd_cnt = 0;
      if (rd_cnt != 0) begin
         rd_cnt--;
         if (rd_cnt == 0) begin
            bus.vram_rvalid = 1'b1;
            bus.vram_rdata = mem[rd_a];
         end
      end
      if (!rst && bus.vram_req && bus.vram_gnt) begin
         tlog.push_back(bus.vram_we);
         if (bus.vram_we) begin
            mem[bus.vram_addr] = bus.vram_wdata;
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_wr: got %h/%h, required no write", bus.vram_addr, bus.vram_wdata);
            end else chk("wr_xfer", {74'd0, bus.vram_addr, bus.vram_wdata}, {74'd0, exp_q.pop_front()});
         end else begin
            rd_a = bus.vram_addr;
            last_ra = bus.vram_addr;
            rd_cnt = rd_lat;
         end
      end
      if (v_load) vl_n++;
      if (oam_we) begin
         oam_n++;
         oam_la = oam_addr;
         oam_ld = oam_wdata;
      end
   end
   task automatic acc(input logic rw, input logic [2:0] a, input logic [7:0] d);
      @(negedge clk);
      bus.cpu_cs = 1'b1;
      bus.cpu_rw = rw;
      bus.cpu_addr = a;
      bus.cpu_data_i = d;
      @(negedge clk);
      bus.cpu_cs = 1'b0;
      @(negedge clk);
   endtask
   task automatic do_reset();
      rst = 1'b1;
      bus.cpu_cs = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      tlog.delete();
      vl_n = 0;
      oam_n = 0;
      @(negedge clk);
   endtask
   task automatic drain(input string nm);
      int k = 0, q = 0;
      while (q < 4 && k < 300) begin
         @(negedge clk);
         k++;
         q = (bus.vram_req || rd_cnt != 0 || exp_q.size() != 0) ? 0 : q + 1;
      end
      chk({nm, "_timeout"}, 96'(k >= 300), 96'd0);
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      logic [1:0] ord;
      bus.cpu_cs = 0; bus.cpu_rw = 0; bus.cpu_addr = 0; bus.cpu_data_i = 0; bus.vram_gnt = 1;
      vblank_set = 0; vblank_clr = 0; sp0 = 0; sp_of = 0; pal_rdata = 0; oam_rdata = 0;
      for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
      tbl[0]  = '{0, 3'd0, 8'h80, 8'h80, 8'h00, 15'h0000, 3'd0, 15'h0000, 8'h80};
      tbl[1]  = '{0, 3'd1, 8'h1E, 8'h80, 8'h1E, 15'h0000, 3'd0, 15'h0000, 8'h1E};
      tbl[2]  = '{0, 3'd5, 8'h7D, 8'h80, 8'h1E, 15'h000F, 3'd5, 15'h0000, 8'h7D};
      tbl[3]  = '{0, 3'd5, 8'h5E, 8'h80, 8'h1E, 15'h616F, 3'd5, 15'h0000, 8'h5E};
      tbl[4]  = '{0, 3'd0, 8'h03, 8'h03, 8'h1E, 15'h6D6F, 3'd5, 15'h0000, 8'h03};
      tbl[5]  = '{0, 3'd6, 8'h21, 8'h03, 8'h1E, 15'h216F, 3'd5, 15'h0000, 8'h21};
      tbl[6]  = '{0, 3'd6, 8'h08, 8'h03, 8'h1E, 15'h2108, 3'd5, 15'h2108, 8'h08};
      tbl[7]  = '{1, 3'd2, 8'h00, 8'h03, 8'h1E, 15'h2108, 3'd5, 15'h2108, 8'h48};
      tbl[8]  = '{0, 3'd6, 8'h3F, 8'h03, 8'h1E, 15'h3F08, 3'd5, 15'h2108, 8'h3F};
      tbl[9]  = '{1, 3'd2, 8'h00, 8'h03, 8'h1E, 15'h3F08, 3'd5, 15'h2108, 8'h5F};
      tbl[10] = '{0, 3'd6, 8'h23, 8'h03, 8'h1E, 15'h2308, 3'd5, 15'h2108, 8'h23};
      tbl[11] = '{0, 3'd6, 8'hC0, 8'h03, 8'h1E, 15'h23C0, 3'd5, 15'h23C0, 8'hC0};
      tbl[12] = '{0, 3'd0, 8'h01, 8'h01, 8'h1E, 15'h27C0, 3'd5, 15'h23C0, 8'h01};
      tbl[13] = '{1, 3'd0, 8'h00, 8'h01, 8'h1E, 15'h27C0, 3'd5, 15'h23C0, 8'h01};
      do_reset();
      chk("reset", {26'd0, ctrl, mask, t, v, fine_x, bus.cpu_data_o, bus.vram_req, nmi, fifo_ovf, oam_addr, oam_we, v_load}, 96'd0);
      sp0 = 1'b1;
      for (int i = 0; i < 14; i++) begin
         acc(tbl[i].rw, tbl[i].a, tbl[i].d);
         chk($sformatf("vec%0d", i), {39'd0, ctrl, mask, t, fine_x, v, bus.cpu_data_o},
             {39'd0, tbl[i].ctrl, tbl[i].mask, tbl[i].t, tbl[i].fx, tbl[i].v, tbl[i].dout});
      end
      sp0 = 1'b0;
      chk("vload_cnt", 96'(vl_n), 96'd2);
      // PPUADDR then one posted write
      do_reset();
      acc(0, 6, 8'h21); acc(0, 6, 8'h08);
      chk("tp1_v", 96'(v), 96'h2108);
      chk("tp1_vload", 96'(vl_n), 96'd1);
      exp_q.push_back({14'h2108, 8'h55});
      acc(0, 7, 8'h55);
      drain("tp1");
      chk("tp1_v_inc", 96'(v), 96'h2109);
      // FIFO overflow with grant held low
      do_reset();
      acc(0, 6, 8'h21); acc(0, 6, 8'h00); acc(0, 0, 8'h04);
      bus.vram_gnt = 1'b0;
      for (int i = 0; i < 5; i++) begin
         logic [13:0] a;
         a = 14'h2100 + 14'(32 * i);
         if (i < 4) exp_q.push_back({a, 8'h10 + 8'(i)});
         acc(0, 7, 8'h10 + 8'(i));
      end
      chk("tp2_ovf", 96'(fifo_ovf), 96'd1);
      chk("tp2_v", 96'(v), 96'h21A0);
      chk("tp2_nowr", 96'(tlog.size()), 96'd0);
      acc(1, 2, 8'h00);
      chk("tp2_ovf_clr", 96'(fifo_ovf), 96'd0);
      bus.vram_gnt = 1'b1;
      drain("tp2");
      chk("tp2_nxfer", 96'(tlog.size()), 96'd4);
      // read buffer delay
      do_reset();
      mem[14'h2000] = 8'hAA; mem[14'h2001] = 8'hBB;
      acc(0, 6, 8'h20); acc(0, 6, 8'h00);
      acc(1, 7, 8'h00);
      chk("tp3_rd0", 96'(bus.cpu_data_o), 96'h00);
      drain("tp3a");
      acc(1, 7, 8'h00);
      chk("tp3_rd1", 96'(bus.cpu_data_o), 96'hAA);
      chk("tp3_v", 96'(v), 96'h2002);
      drain("tp3b");
      // write must drain before the refill of the same address
      do_reset();
      bus.vram_gnt = 1'b0;
      acc(0, 6, 8'h24); acc(0, 6, 8'h00);
      exp_q.push_back({14'h2400, 8'h77});
      acc(0, 7, 8'h77);
      acc(0, 6, 8'h24); acc(0, 6, 8'h00);
      acc(1, 7, 8'h00);
      bus.vram_gnt = 1'b1;
      drain("tp4");
      ord = 2'b00;
      if (tlog.size() >= 2) ord = {tlog[0], tlog[1]};
      chk("tp4_order", {62'd0, 32'(tlog.size()), ord}, {62'd0, 32'd2, 2'b10});
      acc(1, 7, 8'h00);
      chk("tp4_raw", 96'(bus.cpu_data_o), 96'h77);
      // palette read
      do_reset();
      acc(0, 6, 8'h3F); acc(0, 6, 8'h01);
      pal_rdata = 8'h1C;
      acc(1, 7, 8'h00);
      chk("tp5_pal", 96'(bus.cpu_data_o), 96'h1C);
      drain("tp5");
      chk("tp5_refill", 96'(last_ra), 96'h2F01);
      chk("tp5_v", 96'(v), 96'h3F02);
      // vblank / nmi and the status-read race
      do_reset();
      acc(0, 0, 8'h80);
      @(negedge clk); vblank_set = 1'b1;
      @(negedge clk); vblank_set = 1'b0;
      chk("tp6_nmi", 96'(nmi), 96'd1);
      acc(1, 2, 8'h00);
      chk("tp6_stat", 96'(bus.cpu_data_o[7]), 96'd1);
      chk("tp6_nmi_clr", 96'(nmi), 96'd0);
      @(negedge clk);
      bus.cpu_cs = 1'b1; bus.cpu_rw = 1'b1; bus.cpu_addr = 3'd2; vblank_set = 1'b1;
      @(negedge clk);
      bus.cpu_cs = 1'b0; vblank_set = 1'b0;
      chk("tp6_race_stat", 96'(bus.cpu_data_o[7]), 96'd0);
      repeat (3) @(negedge clk);
      chk("tp6_race_flag", 96'(nmi), 96'd0);
      @(negedge clk); vblank_set = 1'b1;
      @(negedge clk); vblank_set = 1'b0; vblank_clr = 1'b1;
      @(negedge clk); vblank_clr = 1'b0;
      chk("tp6_vclr", 96'(nmi), 96'd0);
      // OAM port
      do_reset();
      acc(0, 3, 8'h10);
      acc(0, 4, 8'hAB);
      chk("oam_wr", {48'd0, 32'(oam_n), oam_la, oam_ld}, {48'd0, 32'd1, 8'h10, 8'hAB});
      chk("oam_inc", 96'(oam_addr), 96'h11);
      oam_rdata = 8'h5A;
      acc(1, 4, 8'h00);
      chk("oam_rd", {80'd0, bus.cpu_data_o, oam_addr}, {80'd0, 8'h5A, 8'h11});
      acc(0, 3, 8'hFF); acc(0, 4, 8'h01);
      chk("oam_wrap", 96'(oam_addr), 96'h00);
      // second read while the first refill is still outstanding
      do_reset();
      rd_lat = 8;
      mem[14'h2000] = 8'hAA; mem[14'h2001] = 8'hBB;
      acc(0, 6, 8'h20); acc(0, 6, 8'h00);
      acc(1, 7, 8'h00);
      repeat (2) @(negedge clk);
      acc(1, 7, 8'h00);
      chk("rt_stale", 96'(bus.cpu_data_o), 96'h00);
      drain("rt");
      acc(1, 7, 8'h00);
      chk("rt_new", 96'(bus.cpu_data_o), 96'hBB);
      drain("rt2");
      rd_lat = 2;
      // reset in the middle of a pending write request
      bus.vram_gnt = 1'b0;
      acc(0, 7, 8'h33);
      repeat (2) @(negedge clk);
      chk("pre_rst_req", 96'(bus.vram_req), 96'd1);
      rst = 1'b1;
      #1;
      chk("rst_req", 96'(bus.vram_req), 96'd0);
      bus.vram_gnt = 1'b1;
      do_reset();
      repeat (4) @(negedge clk);
      chk("post_rst_idle", 96'(tlog.size()), 96'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/ppu_cpu_bridge.md
Name: ppu_cpu_bridge

Overview:
- Parametrised CPU-side register front end for the PPU: $2000-$2007 decode, PPUADDR/PPUSCROLL write toggle, t/v/fine_x, PPUSTATUS/NMI and OAMADDR/OAMDATA.
- Adds behaviour the present top-level lacks: a posted-write FIFO for PPUDATA and a request/grant VRAM port, so CPU accesses coexist with render fetches.
- Sits between the CPU bus and the PPU VRAM arbiter. The renderer consumes the t, fine_x, ctrl and mask outputs and the v_load pulse.

Parameters:
- ADDR_W, 14: VRAM address width; v and t are ADDR_W+1 bits wide.
- DATA_W, 8: data width of the CPU bus, VRAM and OAM.
- FIFO_DEPTH, 4: depth of the PPUDATA posted-write FIFO; a power of two, 2 or more.
- OAM_AW, 8: OAM address width.

Ports:
- clk, in, 1: clock.
- rst, in, 1: asynchronous active-high reset.
- cpu_cs, in, 1: register select. Accesses are detected on its rising edge.
- cpu_rw, in, 1: 1 = read, 0 = write.
- cpu_addr, in, 3: register index.
- cpu_data_i, in, DATA_W: CPU write data.
- cpu_data_o, out, DATA_W: latched I/O bus value.
- nmi, out, 1: vblank_flag & ctrl[7].
- vblank_set, in, 1: renderer pulse at vblank start.
- vblank_clr, in, 1: renderer pulse at the pre-render line.
- sp0, in, 1: sprite-0 hit status.
- sp_of, in, 1: sprite overflow status.
- ctrl, out, 8: PPUCTRL register.
- mask, out, 8: PPUMASK register.
- t, out, ADDR_W+1: temporary address register.
- fine_x, out, 3: fine X scroll.
- v, out, ADDR_W+1: current address register.
- v_load, out, 1: one-cycle pulse when v is written by the second PPUADDR write.
- vram_req, out, 1: VRAM access request.
- vram_we, out, 1: 1 = write, 0 = read.
- vram_addr, out, ADDR_W: VRAM address.
- vram_wdata, out, DATA_W: VRAM write data.
- vram_gnt, in, 1: grant; the transfer completes in the cycle req & gnt.
- vram_rvalid, in, 1: read data valid.
- vram_rdata, in, DATA_W: read data.
- pal_rdata, in, DATA_W: palette data for the current v, combinational.
- oam_addr, out, OAM_AW: OAM address.
- oam_we, out, 1: OAM write strobe.
- oam_wdata, out, DATA_W: OAM write data.
- oam_rdata, in, DATA_W: OAM read data.
- fifo_ovf, out, 1: sticky overflow flag, cleared by a PPUSTATUS read.

Behaviour:
- Reset (async): all registers, flags and outputs are 0, with two exceptions:
  - FIFO is empty.
  - Request FSM is in IDLE.
- Access strobe: cs_r is cpu_cs delayed one cycle.
  - re = cs & ~cs_r & rw.
  - we = cs & ~cs_r & ~rw.
  - At most one access per cs assertion.
- Every write copies cpu_data_i into cpu_data_o (open-bus latch). cpu_data_o otherwise holds its value.
- Register writes:
  - 0 (PPUCTRL): ctrl <= d; t[11:10] <= d[1:0].
  - 1 (PPUMASK): mask <= d.
  - 3 (OAMADDR): oam_addr <= d.
  - 4 (OAMDATA): oam_we pulses for 1 cycle with oam_wdata = d; oam_addr increments the following cycle, wrapping at 2^OAM_AW.
  - 5 (PPUSCROLL), w=0: t[4:0] <= d[7:3]; fine_x <= d[2:0].
  - 5 (PPUSCROLL), w=1: t[9:5] <= d[7:3]; t[14:12] <= d[2:0].
  - 6 (PPUADDR), w=0: t[14:8] <= {0, d[5:0]}.
  - 6 (PPUADDR), w=1: t[7:0] <= d; v <= {t[14:8], d}; v_load pulses.
  - Writes to 5 and 6 toggle w.
  - 7 (PPUDATA): push {v[ADDR_W-1:0], d} into the FIFO; v += ctrl[2] ? 32 : 1, modulo 2^(ADDR_W+1).
  - 7 with FIFO full: data is dropped, fifo_ovf <= 1, v still increments.
- Register reads:
  - 2 (PPUSTATUS): cpu_data_o[7:5] <= {vblank_flag, sp0, sp_of}; bits 4:0 hold the latch. Then vblank_flag <= 0, w <= 0, fifo_ovf <= 0.
  - 4 (OAMDATA): cpu_data_o <= oam_rdata; no increment.
  - 7 (PPUDATA), non-palette: cpu_data_o <= readbuf.
  - 7 (PPUDATA), palette (v[13:8] == 6'h3F): cpu_data_o <= pal_rdata.
  - 7, both cases: a refill read of address v[ADDR_W-1:0] is queued, then v increments as for writes. For palette reads the refill address has bit 12 cleared (nametable mirror).
  - Registers 0, 1, 3, 5 and 6 return the latch unchanged.
- vblank_flag:
  - Set by vblank_set.
  - Cleared by vblank_clr or a PPUSTATUS read.
  - A status read in the same cycle as vblank_set returns 0 and the flag is not set (race suppression).
- Request FSM:
  - IDLE: if the FIFO is not empty go to WR; else if a refill is pending go to RD.
  - WR: drive req=1, we=1, addr/wdata from the FIFO head. On gnt, pop the head. Then go to WR if the FIFO is still not empty, else RD if a refill is pending, else IDLE.
  - RD: drive req=1, we=0, refill address. On gnt go to RWAIT.
  - RWAIT: on vram_rvalid, readbuf <= vram_rdata, clear the pending flag, go to IDLE.
- Ordering: writes always drain before a refill, so read-after-write returns the new data.
- A PPUDATA read while a refill is pending returns the stale readbuf and re-targets the pending address to the new v.
  - If already in RWAIT, the returning data is discarded and the FSM reissues the read from the new address.
- Simultaneous FIFO push and pop: count is unchanged. A full FIFO that pops in the same cycle accepts the push.
- Reset mid-transaction abandons the request; vram_req is 0 immediately.

Test Plan:
- PPUADDR $21,$08; PPUDATA write $55 with ctrl[2]=0 -> v_load pulses with v=$2108; one WR transfer at $2108 data $55; v=$2109.
- ctrl[2]=1; five PPUDATA writes with gnt held low, FIFO_DEPTH=4 -> 4 entries queued, fifo_ovf=1, v advanced by 5×32; PPUSTATUS read clears fifo_ovf.
- v=$2000, VRAM holds $AA, $BB; two PPUDATA reads spaced past rvalid -> first returns the reset readbuf (0), second returns $AA; v=$2002.
- PPUDATA write $77 to $2400 then immediately a read of $2400 -> WR is granted before RD; the next read returns $77.
- v=$3F01, pal_rdata=$1C -> read returns $1C immediately; refill address is $2F01.
- vblank_set with ctrl[7]=1 -> nmi=1; PPUSTATUS returns bit7=1 and nmi drops. Repeat with the read coincident with vblank_set -> returns 0 and the flag stays 0.
